// File: rtl/writeback_queue.sv
// Register-file write-back queue: buffers ALU and load results, drains one per
// cycle oldest-first, and forwards the youngest pending value for two read ports.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module writeback_queue #(
  parameter int REGISTER_COUNT = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(REGISTER_COUNT),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   AluValid,
  output logic                   AluReady,
  input  logic [AW-1:0]          AluAdr,
  input  logic [`BIT_COUNT-1:0]  AluData,
  input  logic                   LoadValid,
  output logic                   LoadReady,
  input  logic [AW-1:0]          LoadAdr,
  input  logic [`BIT_COUNT-1:0]  LoadData,
  output logic                   WriteEnable,
  output logic [AW-1:0]          rd1Adr,
  output logic [`BIT_COUNT-1:0]  Rd1,
  input  logic [AW-1:0]          rs1Adr,
  input  logic [AW-1:0]          rs2Adr,
  output logic                   Rs1Hit,
  output logic                   Rs2Hit,
  output logic [`BIT_COUNT-1:0]  Rs1Fwd,
  output logic [`BIT_COUNT-1:0]  Rs2Fwd,
  output logic [CW-1:0]          Count
);

  localparam int W  = `BIT_COUNT;
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] adr_q  [DEPTH];
  logic [W-1:0]  data_q [DEPTH];
  logic [PW-1:0] head, tail, load_slot;
  logic [CW-1:0] count, free, count_next;
  logic          alu_store, load_store, pop;

  // Free space ignores this cycle's drain, so a full queue never accepts.
  always_comb begin
    free       = CW'(DEPTH) - count;
    AluReady   = !reset && (free >= CW'(1));
    LoadReady  = !reset && (free >= (AluValid ? CW'(2) : CW'(1)));
    alu_store  = AluValid && AluReady && (AluAdr != '0);
    load_store = LoadValid && LoadReady && (LoadAdr != '0);
    load_slot  = alu_store ? tail + PW'(1) : tail;
    pop        = (count != '0);
    count_next = count + CW'(alu_store) + CW'(load_store) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      tail  <= tail + PW'(alu_store) + PW'(load_store);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (alu_store) begin
      adr_q[tail]  <= AluAdr;
      data_q[tail] <= AluData;
    end
    if (load_store) begin
      adr_q[load_slot]  <= LoadAdr;
      data_q[load_slot] <= LoadData;
    end
  end

  assign WriteEnable = pop;
  assign rd1Adr      = pop ? adr_q[head]  : '0;
  assign Rd1         = pop ? data_q[head] : '0;
  assign Count       = count;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = '0;
    Rs1Hit = 1'b0;
    Rs2Hit = 1'b0;
    Rs1Fwd = '0;
    Rs2Fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (rs1Adr != '0 && adr_q[idx] == rs1Adr) begin
          Rs1Hit = 1'b1;
          Rs1Fwd = data_q[idx];
        end
        if (rs2Adr != '0 && adr_q[idx] == rs2Adr) begin
          Rs2Hit = 1'b1;
          Rs2Fwd = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: stimulus pushes expected writes, a
// negedge monitor pops and compares every register-file write it sees.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module tb_writeback_queue;

  localparam int AW    = 5;
  localparam int W     = `BIT_COUNT;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [W-1:0]  data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          AluValid, AluReady, LoadValid, LoadReady;
  logic [AW-1:0] AluAdr, LoadAdr, rd1Adr, rs1Adr, rs2Adr;
  logic [W-1:0]  AluData, LoadData, Rd1, Rs1Fwd, Rs2Fwd;
  logic          WriteEnable, Rs1Hit, Rs2Hit;
  logic [CW-1:0] Count;

  wr_t           sb[$];
  wr_t           mon_entry;
  int            checks = 0;
  int            errors = 0;
  int            model_count = 0;
  logic          fwd_en = 1'b0;
  logic          exp_hit1, exp_hit2;
  logic [W-1:0]  exp_fwd1, exp_fwd2;
  logic          last_load_ready, last_alu_ready;
  logic [CW-1:0] last_count;

  always #5 clk = ~clk;

  writeback_queue #(.REGISTER_COUNT(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .AluValid(AluValid), .AluReady(AluReady), .AluAdr(AluAdr), .AluData(AluData),
    .LoadValid(LoadValid), .LoadReady(LoadReady), .LoadAdr(LoadAdr), .LoadData(LoadData),
    .WriteEnable(WriteEnable), .rd1Adr(rd1Adr), .Rd1(Rd1),
    .rs1Adr(rs1Adr), .rs2Adr(rs2Adr), .Rs1Hit(Rs1Hit), .Rs2Hit(Rs2Hit),
    .Rs1Fwd(Rs1Fwd), .Rs2Fwd(Rs2Fwd), .Count(Count)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write the DUT presents must be the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (WriteEnable === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got adr %0d data 0x%0h, expected no write", rd1Adr, Rd1);
        end else begin
          mon_entry = sb.pop_front();
          checkOutput("write_adr", 64'(rd1Adr), 64'(mon_entry.adr));
          checkOutput("write_data", 64'(Rd1), 64'(mon_entry.data));
        end
      end else begin
        checkOutput("idle_adr", 64'(rd1Adr), 64'd0);
        checkOutput("idle_data", 64'(Rd1), 64'd0);
      end
    end
  end

  // One cycle: drive, check against the occupancy model at negedge, then
  // record accepted writes at the edge.
  task automatic applyStimulus(input logic av, input logic [AW-1:0] aa, input logic [W-1:0] ad,
                               input logic lv, input logic [AW-1:0] la, input logic [W-1:0] ld,
                               output logic alu_acc, output logic load_acc);
    int free;
    logic exp_ar, exp_lr;
    AluValid = av; AluAdr = aa; AluData = ad;
    LoadValid = lv; LoadAdr = la; LoadData = ld;
    @(negedge clk);
    free   = DEPTH - model_count;
    exp_ar = (free >= 1);
    exp_lr = (free >= (av ? 2 : 1));
    last_count      = Count;
    last_load_ready = LoadReady;
    last_alu_ready  = AluReady;
    checkOutput("count", 64'(Count), 64'(model_count));
    checkOutput("write_enable", 64'(WriteEnable), 64'(model_count != 0));
    checkOutput("alu_ready", 64'(AluReady), 64'(exp_ar));
    checkOutput("load_ready", 64'(LoadReady), 64'(exp_lr));
    if (fwd_en) begin
      checkOutput("rs1_hit", 64'(Rs1Hit), 64'(exp_hit1));
      checkOutput("rs1_fwd", 64'(Rs1Fwd), 64'(exp_fwd1));
      checkOutput("rs2_hit", 64'(Rs2Hit), 64'(exp_hit2));
      checkOutput("rs2_fwd", 64'(Rs2Fwd), 64'(exp_fwd2));
    end
    @(posedge clk);
    alu_acc  = av && exp_ar;
    load_acc = lv && exp_lr;
    if (model_count != 0) model_count--;
    if (alu_acc && aa != 0) begin sb.push_back('{adr: aa, data: ad}); model_count++; end
    if (load_acc && la != 0) begin sb.push_back('{adr: la, data: ld}); model_count++; end
    #1;
  endtask

  task automatic idleCycle();
    logic a, l;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, a, l);
  endtask

  task automatic expectFwd(input logic h1, input logic [W-1:0] f1, input logic h2, input logic [W-1:0] f2);
    fwd_en = 1'b1;
    exp_hit1 = h1; exp_fwd1 = f1; exp_hit2 = h2; exp_fwd2 = f2;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && model_count != 0; i++) idleCycle();
    checkOutput("drain_timeout", 64'(model_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic a, l;
    int k;
    int bp_count[6] = '{0, 2, 3, 3, 3, 3};
    int bp_load[6]  = '{1, 1, 0, 0, 0, 0};

    reset = 1'b1;
    AluValid = 1'b0; LoadValid = 1'b0;
    AluAdr = '0; LoadAdr = '0; AluData = '0; LoadData = '0;
    rs1Adr = '0; rs2Adr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] reset state");
    rs1Adr = 5'd5; rs2Adr = 5'd3;
    expectFwd(1'b0, '0, 1'b0, '0);
    idleCycle();

    $display("[TB] single write");
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, a, l);
    expectFwd(1'b1, 32'h1234, 1'b0, '0);
    idleCycle();
    checkOutput("single_count1", 64'(last_count), 64'd1);
    expectFwd(1'b0, '0, 1'b0, '0);
    idleCycle();
    checkOutput("single_count0", 64'(last_count), 64'd0);

    $display("[TB] simultaneous same destination");
    rs1Adr = 5'd3; rs2Adr = 5'd4;
    applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, a, l);
    expectFwd(1'b1, 32'hB, 1'b0, '0);
    idleCycle();
    idleCycle();
    expectFwd(1'b0, '0, 1'b0, '0);
    idleCycle();

    $display("[TB] backpressure");
    fwd_en = 1'b0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, AW'(i + 1), 32'h200 + 32'(i), 1'b1, AW'(k + 20), 32'h300 + 32'(k), a, l);
      checkOutput("bp_count", 64'(last_count), 64'(bp_count[i]));
      checkOutput("bp_load_ready", 64'(last_load_ready), 64'(bp_load[i]));
      checkOutput("bp_alu_ready", 64'(last_alu_ready), 64'd1);
      if (l) k++;
    end
    drain();

    $display("[TB] x0 write");
    rs1Adr = 5'd0; rs2Adr = 5'd0;
    expectFwd(1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, a, l);
    checkOutput("x0_alu_ready", 64'(last_alu_ready), 64'd1);
    idleCycle();
    checkOutput("x0_count", 64'(last_count), 64'd0);

    $display("[TB] reset mid-operation");
    fwd_en = 1'b0;
    rs1Adr = 5'd9; rs2Adr = 5'd10;
    applyStimulus(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, a, l);
    applyStimulus(1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0, a, l);
    checkOutput("pre_reset_model", 64'(model_count), 64'd3);
    reset = 1'b1;
    AluValid = 1'b1; AluAdr = 5'd11; AluData = 32'hB0;
    LoadValid = 1'b1; LoadAdr = 5'd12; LoadData = 32'hC0;
    @(negedge clk);
    checkOutput("reset_count3", 64'(Count), 64'd3);
    checkOutput("reset_alu_ready", 64'(AluReady), 64'd0);
    checkOutput("reset_load_ready", 64'(LoadReady), 64'd0);
    @(posedge clk);
    sb.delete();
    model_count = 0;
    #1 reset = 1'b0;
    expectFwd(1'b0, '0, 1'b0, '0);
    repeat (3) idleCycle();

    $display("[TB] wrap-around");
    fwd_en = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      applyStimulus(1'b1, AW'(n), 32'h100 + 32'(n), 1'b0, '0, '0, a, l);
      checkOutput("wrap_count", 64'(last_count), 64'(n == 1 ? 0 : 1));
    end
    drain();
    idleCycle();

    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
